// File: rtl/div_iter_unit_if.sv
// -----------------------------------------------------------------------------
// div_iter_unit_if
// Handshake/result bundle between the CPU datapath and the iterative divider.
//   master : datapath side (drives start/operands, receives results)
//   slave  : divider side
// Signals:
//   start        launch request (one pulse)
//   abort        cancel an operation in flight (only when DIV_ABORT_EN is defined)
//   is_signed    1 = DIV, 0 = DIVU
//   dividend     rs operand
//   divisor      rt operand
//   busy         operation in flight
//   done         one-cycle result strobe
//   quotient     result for LO
//   remainder    result for HI
//   div_by_zero  last operation had a zero divisor
// Optional feature macro: DIV_ABORT_EN
// -----------------------------------------------------------------------------
interface div_iter_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
`ifdef DIV_ABORT_EN
    logic             abort;
`endif
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

`ifdef DIV_ABORT_EN
    modport master (
        output start, abort, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );
    modport slave (
        input  start, abort, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
`else
    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );
    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
`endif
endinterface

// File: rtl/div_iter_unit.sv
// -----------------------------------------------------------------------------
// div_iter_unit
// Radix-2 restoring divider for DIV/DIVU. One quotient bit per falling edge of
// CLK; operands are converted to magnitudes on launch and the signs are applied
// in a single fix-up cycle. Divide-by-zero skips the iterations entirely.
// Ports:
//   CLK    clock, all state changes on the falling edge
//   RST_n  asynchronous reset, active HIGH despite the name
//   bus    div_iter_unit_if.slave (start/operands in, busy/done/results out)
// Parameters:
//   WIDTH  operand width (>= 2)
//   CNT_W  iteration counter width, 2**CNT_W > WIDTH
// Optional feature macro: DIV_ABORT_EN (adds bus.abort, cancels RUN/FIX)
// -----------------------------------------------------------------------------
module div_iter_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic           CLK,
    input logic           RST_n,
    div_iter_unit_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q;        // partial remainder
    logic [WIDTH-1:0] quo_q;        // dividend bits shifting out / quotient bits shifting in
    logic [WIDTH-1:0] dvs_q;        // divisor magnitude
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;

    logic             a_neg_s;
    logic             b_neg_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic             divz_s;
    logic             abort_s;
    logic [WIDTH:0]   shift_s;
    logic [WIDTH:0]   trial_s;
    logic             fits_s;
    logic [WIDTH-1:0] rem_step_s;
    logic [WIDTH-1:0] quo_step_s;

    // Two's complement negate when neg is set; -2^(W-1) maps onto itself,
    // which is exactly its magnitude when read as unsigned.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    assign a_neg_s = bus.is_signed & bus.dividend[WIDTH-1];
    assign b_neg_s = bus.is_signed & bus.divisor[WIDTH-1];
    assign a_mag_s = cond_neg(bus.dividend, a_neg_s);
    assign b_mag_s = cond_neg(bus.divisor, b_neg_s);
    assign divz_s  = (bus.divisor == {WIDTH{1'b0}});

`ifdef DIV_ABORT_EN
    assign abort_s = bus.abort;
`else
    assign abort_s = 1'b0;
`endif

    // One restoring step. The shifted remainder is kept W+1 bits wide so that
    // divisors with the MSB set do not lose the carried-out bit.
    always_comb begin
        shift_s    = {rem_q, quo_q[WIDTH-1]};
        trial_s    = shift_s - {1'b0, dvs_q};
        fits_s     = ~trial_s[WIDTH];
        quo_step_s = {quo_q[WIDTH-2:0], fits_s};
        if (fits_s) begin
            rem_step_s = trial_s[WIDTH-1:0];
        end else begin
            rem_step_s = shift_s[WIDTH-1:0];
        end
    end

    // Control FSM, iteration datapath and registered outputs.
    always_ff @(negedge CLK or posedge RST_n) begin
        if (RST_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            rem_q       <= {WIDTH{1'b0}};
            quo_q       <= {WIDTH{1'b0}};
            dvs_q       <= {WIDTH{1'b0}};
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= {WIDTH{1'b0}};
            remainder_q <= {WIDTH{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        dbz_q  <= divz_s;
                        if (divz_s) begin
                            // Preload the architectural div-by-zero result so
                            // FIX passes it through unchanged.
                            quo_q     <= {WIDTH{1'b1}};
                            rem_q     <= bus.dividend;
                            neg_quo_q <= 1'b0;
                            neg_rem_q <= 1'b0;
                            cnt_q     <= {CNT_W{1'b0}};
                            state_q   <= ST_FIX;
                        end else begin
                            quo_q     <= a_mag_s;
                            rem_q     <= {WIDTH{1'b0}};
                            dvs_q     <= b_mag_s;
                            neg_quo_q <= a_neg_s ^ b_neg_s;
                            neg_rem_q <= a_neg_s;
                            cnt_q     <= CNT_W'(WIDTH);
                            state_q   <= ST_RUN;
                        end
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (abort_s) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        rem_q <= rem_step_s;
                        quo_q <= quo_step_s;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= ST_FIX;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_FIX: begin
                    if (abort_s) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        quotient_q  <= cond_neg(quo_q, neg_quo_q);
                        remainder_q <= cond_neg(rem_q, neg_rem_q);
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

endmodule
